// File: rtl/elevator_scan_controller.sv
// Per-car motion and door sequencer: accumulates floor requests and serves them
// with a LOOK direction policy, stepping the car in half-floor units.
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int POS_W         = $clog2(2*NUM_FLOORS-1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_FLOORS-1:0] req_set,
  input  logic                  door_hold,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [POS_W-1:0]      position,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive
);

  localparam int STEP_W  = $clog2(TRAVEL_CYCLES + 1);
  localparam int DWELL_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [STEP_W-1:0]  STEP_LOAD  = STEP_W'(TRAVEL_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [POS_W-1:0]        position_q, position_d;
  logic                    direction_q, direction_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    arrive_q, arrive_d;

  logic [POS_W-1:0]        step_pos;
  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   cur_mask;
  logic [NUM_FLOORS-1:0]   eval_mask;
  logic                    eval_above, eval_below;
  logic                    open_req, try_depart;
  logic                    ahead, behind;
  int                      cur_floor, eval_floor;

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input int floor);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == floor) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] req, input int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > floor) r = r | req[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] req, input int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < floor) r = r | req[i];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      position_q  <= '0;
      direction_q <= 1'b1;
      pending_q   <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      arrive_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      position_q  <= position_d;
      direction_q <= direction_d;
      pending_q   <= pending_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      arrive_q    <= arrive_d;
    end
  end

  // Floor evaluation happens against the current floor, or against the floor
  // just reached when a step lands on an even position.
  always_comb begin
    state_d     = state_q;
    position_d  = position_q;
    direction_d = direction_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    arrive_d    = 1'b0;
    clr         = '0;
    open_req    = 1'b0;
    try_depart  = 1'b0;
    ahead       = 1'b0;
    behind      = 1'b0;

    cur_floor  = int'(position_q >> 1);
    cur_mask   = floor_mask(cur_floor);
    step_pos   = direction_q ? position_q + 1'b1 : position_q - 1'b1;
    eval_floor = cur_floor;

    case (state_q)
      IDLE: begin
        if ((pending_q & cur_mask) != '0) open_req = 1'b1;
        else                              try_depart = 1'b1;
      end
      MOVING: begin
        if (step_q != '0) begin
          step_d = step_q - 1'b1;
        end else begin
          position_d = step_pos;
          step_d     = STEP_LOAD;
          if (!step_pos[0]) begin
            eval_floor = int'(step_pos >> 1);
            if ((pending_q & floor_mask(eval_floor)) != '0) open_req = 1'b1;
            else                                            try_depart = 1'b1;
          end
        end
      end
      DOOR_OPEN: begin
        clr = cur_mask;
        if (door_hold || ((req_set & cur_mask) != '0)) dwell_d = DWELL_LOAD;
        else if (dwell_q != '0)                         dwell_d = dwell_q - 1'b1;
        else                                            try_depart = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    eval_mask  = floor_mask(eval_floor);
    eval_above = any_above(pending_q, eval_floor);
    eval_below = any_below(pending_q, eval_floor);

    if (open_req) begin
      state_d  = DOOR_OPEN;
      dwell_d  = DWELL_LOAD;
      arrive_d = 1'b1;
      clr      = clr | eval_mask;
    end else if (try_depart) begin
      ahead  = direction_q ? eval_above : eval_below;
      behind = direction_q ? eval_below : eval_above;
      if (ahead) begin
        state_d = MOVING;
        step_d  = STEP_LOAD;
      end else if (behind) begin
        state_d     = MOVING;
        direction_d = ~direction_q;
        step_d      = STEP_LOAD;
      end else begin
        state_d = IDLE;
      end
    end

    pending_d = (pending_q | req_set) & ~clr;
  end

  assign pending   = pending_q;
  assign position  = position_q;
  assign direction = direction_q;
  assign moving    = (state_q == MOVING);
  assign door_open = (state_q == DOOR_OPEN);
  assign arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: vector table, directed corner sequences and
// randomized traffic checked every cycle against a floor-level behavioural model.
module tb_elevator_scan_controller;

  localparam int NF     = 6;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 8;
  localparam int PW     = $clog2(2*NF-1);
  localparam int BUDGET = 400;

  logic          clk;
  logic          n_rst;
  logic [NF-1:0] req_set;
  logic          door_hold;
  logic [NF-1:0] pending;
  logic [PW-1:0] position;
  logic          direction, moving, door_open, arrive;

  int checks = 0;
  int errors = 0;

  elevator_scan_controller #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL), .POS_W(PW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .req_set(req_set), .door_hold(door_hold),
    .pending(pending), .position(position), .direction(direction),
    .moving(moving), .door_open(door_open), .arrive(arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference car: mode 0 idle, 1 travelling, 2 door open; pos in half-floors.
  int      m_mode = 0;
  int      m_pos = 0;
  bit      m_dir = 1'b1;
  bit [NF-1:0] m_pend = '0;
  int      m_timer = 0;
  bit      m_arrive = 1'b0;

  function automatic bit calls_up(input int fl);
    for (int f = fl + 1; f < NF; f++) if (m_pend[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_down(input int fl);
    for (int f = 0; f < fl; f++) if (m_pend[f]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic rst_n, input logic [NF-1:0] req, input logic hold);
    int fl;
    bit [NF-1:0] nxt;
    bit stop, decide, up, down;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_dir = 1'b1; m_pend = '0; m_timer = 0; m_arrive = 1'b0;
      return;
    end
    fl = m_pos / 2;
    nxt = m_pend | req;
    stop = 1'b0;
    decide = 1'b0;
    m_arrive = 1'b0;
    if (m_mode == 2) nxt[fl] = 1'b0;
    case (m_mode)
      0: if (m_pend[fl]) stop = 1'b1; else decide = 1'b1;
      1: begin
        if (m_timer > 0) m_timer--;
        else begin
          m_pos = m_pos + (m_dir ? 1 : -1);
          m_timer = TRAVEL - 1;
          if (m_pos % 2 == 0) begin
            fl = m_pos / 2;
            if (m_pend[fl]) stop = 1'b1; else decide = 1'b1;
          end
        end
      end
      default: begin
        if (hold || req[fl]) m_timer = DWELL - 1;
        else if (m_timer > 0) m_timer--;
        else decide = 1'b1;
      end
    endcase
    if (stop) begin
      m_mode = 2; m_timer = DWELL - 1; m_arrive = 1'b1; nxt[fl] = 1'b0;
    end else if (decide) begin
      up = calls_up(fl);
      down = calls_down(fl);
      if (m_dir ? up : down) begin
        m_mode = 1; m_timer = TRAVEL - 1;
      end else if (m_dir ? down : up) begin
        m_mode = 1; m_dir = !m_dir; m_timer = TRAVEL - 1;
      end else begin
        m_mode = 0;
      end
    end
    m_pend = nxt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [NF-1:0] req, input logic hold);
    n_rst = rst_n;
    req_set = req;
    door_hold = hold;
    model_step(rst_n, req, hold);
    @(negedge clk);
    checkOutput("model{pend,pos,dir,mv,door,arr}",
                {pending, position, direction, moving, door_open, arrive},
                {m_pend, PW'(m_pos), m_dir, m_mode == 1, m_mode == 2, m_arrive});
  endtask

  task automatic waitArrive(input string name);
    int n = 0;
    do begin
      applyStimulus(1'b1, '0, 1'b0);
      n++;
    end while (arrive !== 1'b1 && n < BUDGET);
    checkOutput(name, arrive, 1);
  endtask

  task automatic waitPos(input string name, input int p);
    int n = 0;
    do begin
      applyStimulus(1'b1, '0, 1'b0);
      n++;
    end while (position !== PW'(p) && n < BUDGET);
    checkOutput(name, position, p);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      applyStimulus(1'b1, '0, 1'b0);
      n++;
    end while ((moving !== 1'b0 || door_open !== 1'b0) && n < BUDGET);
    checkOutput(name, {moving, door_open}, 0);
  endtask

  typedef struct {
    logic          n_rst;
    logic [NF-1:0] req;
    logic          hold;
    int            hold_cycles;
    int            idle_cycles;
    logic [NF-1:0] exp_pending;
    logic [PW-1:0] exp_pos;
    logic          exp_dir;
    logic          exp_moving;
    logic          exp_door;
    logic          exp_arrive;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cnt, n;
    logic [NF-1:0] r;
    n_rst = 1'b0;
    req_set = '0;
    door_hold = 1'b0;

    vecs[0] = '{1'b0, 6'h3F,      1'b0, 3, 0,  6'h00,      4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 6'b001000,  1'b0, 1, 0,  6'b001000,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 6'h00,      1'b0, 0, 1,  6'b001000,  4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 6'h00,      1'b0, 0, 4,  6'b001000,  4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 6'h00,      1'b0, 0, 19, 6'b001000,  4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 6'h00,      1'b0, 0, 1,  6'h00,      4'd6, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 6'h00,      1'b0, 0, 1,  6'h00,      4'd6, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 6'h00,      1'b0, 0, 6,  6'h00,      4'd6, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 6'h00,      1'b0, 0, 1,  6'h00,      4'd6, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      repeat (vecs[i].hold_cycles) applyStimulus(vecs[i].n_rst, vecs[i].req, vecs[i].hold);
      repeat (vecs[i].idle_cycles) applyStimulus(1'b1, '0, 1'b0);
      checkOutput($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pending);
      checkOutput($sformatf("vec%0d_position", i), position, vecs[i].exp_pos);
      checkOutput($sformatf("vec%0d_direction", i), direction, vecs[i].exp_dir);
      checkOutput($sformatf("vec%0d_moving", i), moving, vecs[i].exp_moving);
      checkOutput($sformatf("vec%0d_door_open", i), door_open, vecs[i].exp_door);
      checkOutput($sformatf("vec%0d_arrive", i), arrive, vecs[i].exp_arrive);
    end

    // En-route pickup: floor 2 requested while passing position 1 toward floor 5.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 6'b100000, 1'b0);
    waitPos("pickup_reach1", 1);
    applyStimulus(1'b1, 6'b000100, 1'b0);
    waitArrive("pickup_arrive");
    checkOutput("pickup_pos", position, 4);
    checkOutput("pickup_pending", pending, 6'b100000);
    waitArrive("pickup_top_arrive");
    checkOutput("pickup_top_pos", position, 10);

    // Passed floor: floor 2 requested at position 5 is served after floor 5.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 6'b100000, 1'b0);
    waitPos("passed_reach5", 5);
    applyStimulus(1'b1, 6'b000100, 1'b0);
    waitArrive("passed_first_arrive");
    checkOutput("passed_first_pos", position, 10);
    waitArrive("passed_second_arrive");
    checkOutput("passed_second_pos", position, 4);
    checkOutput("passed_second_dir", direction, 0);

    // LOOK reversal from idle at floor 3 with calls at floors 5 and 1.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 6'b001000, 1'b0);
    waitArrive("look_start_arrive");
    waitIdle("look_start_idle");
    checkOutput("look_start_dir", direction, 1);
    applyStimulus(1'b1, 6'b100010, 1'b0);
    waitArrive("look_up_arrive");
    checkOutput("look_up_pos", position, 10);
    waitArrive("look_down_arrive");
    checkOutput("look_down_pos", position, 2);
    checkOutput("look_down_dir", direction, 0);
    waitIdle("look_end_idle");
    checkOutput("look_end_pending", pending, 0);

    // Door hold from the third open cycle for 20 cycles.
    applyStimulus(1'b1, 6'b000100, 1'b0);
    waitArrive("hold_arrive");
    checkOutput("hold_pos", position, 4);
    cnt = 1;
    repeat (2) begin
      applyStimulus(1'b1, '0, 1'b0);
      cnt += int'(door_open);
    end
    repeat (20) begin
      applyStimulus(1'b1, '0, 1'b1);
      cnt += int'(door_open);
    end
    n = 0;
    do begin
      applyStimulus(1'b1, '0, 1'b0);
      cnt += int'(door_open);
      n++;
    end while (door_open === 1'b1 && n < BUDGET);
    checkOutput("hold_open_cycles", cnt, 30);

    // Request for the open floor restarts the dwell and never becomes pending.
    applyStimulus(1'b1, 6'b000100, 1'b0);
    waitArrive("reopen_arrive");
    cnt = 1;
    repeat (3) begin
      applyStimulus(1'b1, '0, 1'b0);
      cnt += int'(door_open);
    end
    applyStimulus(1'b1, 6'b000100, 1'b0);
    cnt += int'(door_open);
    checkOutput("reopen_pending", pending, 0);
    n = 0;
    do begin
      applyStimulus(1'b1, '0, 1'b0);
      cnt += int'(door_open);
      n++;
    end while (door_open === 1'b1 && n < BUDGET);
    checkOutput("reopen_open_cycles", cnt, 12);

    // Reset while moving up at position 7.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 6'b100000, 1'b0);
    waitPos("midmove_reach7", 7);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midmove_state",
                {pending, position, direction, moving, door_open, arrive},
                {6'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int k = 0; k < 3000; k++) begin
      r = '0;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
      applyStimulus(($urandom_range(0, 299) != 0), r, ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Per-car motion and door sequencer for the elevator controller, parametrised in floor count, travel time and door dwell time. It accumulates floor requests (destinations and hall calls, pre-ORed per car) into a pending register. It runs a LOOK-style direction policy: keep direction while requests lie ahead, reverse otherwise, and idle when none remain. It steps the car position in half-floor units. One instance per car; the two-car system instantiates it twice with NUM_FLOORS=6.

## Interface
- NUM_FLOORS, 6, floor count (≥2)
- TRAVEL_CYCLES, 4, cycles per half-floor step (≥1)
- DOOR_CYCLES, 8, minimum door-open dwell in cycles (≥1)
- POS_W, $clog2(2*NUM_FLOORS-1), derived width of the position output
- clk  in  1  sole clock; every register updates on its rising edge
- n_rst  in  1  reset, synchronous, active-low
- req_set  in  NUM_FLOORS  per-floor request level; ORed into pending every cycle
- door_hold  in  1  extends door-open while high
- pending  out  NUM_FLOORS  outstanding requests
- position  out  POS_W  car position in half-floors (0..2*NUM_FLOORS-2); even value = at floor position/2
- direction  out  1  1 = up, 0 = down
- moving  out  1  state is MOVING
- door_open  out  1  state is DOOR_OPEN
- arrive  out  1  one-cycle pulse on entry to DOOR_OPEN

## Operation
- States: IDLE (at floor, door closed), MOVING, DOOR_OPEN.
- pending_next = (pending | req_set) & ~clr.
  - clr = bit of floor cur on entry to DOOR_OPEN.
  - clr = bit cur every cycle while in DOOR_OPEN. A request for the open floor never becomes pending.
- cur = position>>1. above = |pending[NUM_FLOORS-1:cur+1]. below = |pending[cur-1:0]. Both use the registered pending.
- ahead = direction ? above : below. behind = direction ? below : above.
- Departure decision, used in IDLE, at dwell end and at even-position arrival:
  - If ahead: MOVING, direction unchanged.
  - Else if behind: MOVING, direction toggled.
  - Else: IDLE.
- IDLE:
  - If pending[cur]: go to DOOR_OPEN. This takes priority over departure.
  - Otherwise apply the departure decision.
  - With requests on both sides, direction is kept.
- MOVING:
  - Step timer is loaded with TRAVEL_CYCLES-1 on entry and on each step, and counts down.
  - At 0: position ±1 per direction.
  - If the new position is odd: stay MOVING. No reversal between floors.
  - If the new position is even: evaluate against the new floor. pending[new floor] → DOOR_OPEN; otherwise apply the departure decision.
- DOOR_OPEN:
  - Dwell counter is loaded with DOOR_CYCLES-1 on entry and counts down.
  - door_hold=1 or req_set[cur]=1 reloads it to DOOR_CYCLES-1.
  - At 0 with no reload: apply the departure decision.
- Range safety: the car never steps above the top floor or below floor 0. Nothing can be pending beyond an end floor, so the policy never selects that move.

## Timing
- Reset values (n_rst=0 at an edge): state IDLE, position 0, direction 1, pending 0, moving 0, door_open 0, arrive 0, both timers 0. A reset mid-move or mid-dwell applies the same values on that edge.
- All outputs are registered. req_set high at edge t → pending bit visible at t+1 → state reacts at t+2 from IDLE.
- If MOVING is first visible in cycle m, position p±1 is visible at m+TRAVEL_CYCLES.
- One floor takes 2*TRAVEL_CYCLES cycles.
- Stop at a floor: position even, door_open=1 and arrive=1 in the same cycle.
- door_open lasts exactly DOOR_CYCLES cycles after the last reload.
- A request arriving at the same edge as the arrival evaluation is not seen until the next floor.

## Test plan
- Reset: hold n_rst=0 for 3 cycles with req_set=6'h3F → position 0, direction 1, pending 0, moving/door_open/arrive 0.
- Single call: from floor 0 idle, req_set=6'b001000 for 1 cycle → pending=6'b001000 next cycle; moving=1 one cycle later (cycle m). At m+24: position=6, door_open=1, arrive=1, pending=0. door_open stays high m+24..m+31, then IDLE.
- En-route pickup / passed floor:
  - Heading to floor 5 at position 1: req floor 2 → stops at position 4.
  - At position 5: req floor 2 → not served until after floor 5, then direction=0 and stop at position 4.
- LOOK reversal: idle at floor 3, direction 1, pending floors 5 and 1 → serves floor 5 (position 10), direction toggles to 0, then serves floor 1 (position 2), then IDLE.
- Door hold: door open at floor 2 with door_hold=1 for 20 cycles from dwell cycle 3 → door_open total 3+20+7=30 cycles. req_set[2] pulsed during the open period → pending[2] stays 0 and the dwell restarts.
- Reset mid-move: n_rst=0 for one edge at position 7 moving up → next cycle position 0, IDLE, pending 0.
